// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the bit-serial adder controller.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } state_e;

  // Bit-counter width; a one-bit operand still needs a one-bit counter.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/full_adder.sv
// Gate-level one-bit full adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic co
);

  logic axb;

  assign axb = a ^ b;
  assign sum = axb ^ cin;
  assign co  = (a & b) | (axb & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell sequenced over WIDTH cycles, LSB first,
// with a registered sum/carry-out and a one-cycle done pulse.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CntW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d;
  logic [WIDTH-1:0] rb_q, rb_d;
  logic [WIDTH-1:0] ra_next;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             fa_s, fa_co;
  logic             last_bit;

  full_adder u_fa (
    .a   (ra_q[0]),
    .b   (rb_q[0]),
    .cin (carry_q),
    .sum (fa_s),
    .co  (fa_co)
  );

  // Operand A doubles as the sum accumulator: each sum bit enters at the MSB
  // as the consumed operand bit leaves at the LSB.
  if (WIDTH == 1) begin : g_acc_one
    assign ra_next = fa_s;
  end else begin : g_acc_wide
    assign ra_next = {fa_s, ra_q[WIDTH-1:1]};
  end

  assign last_bit = (cnt_q == CntW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          ra_d    = a;
          rb_d    = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        ra_d    = ra_next;
        rb_d    = rb_q >> 1;
        carry_d = fa_co;
        cnt_d   = cnt_q + CntW'(1);
        if (last_bit) begin
          sum_d   = ra_next;
          cout_d  = fa_co;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      ra_q    <= '0;
      rb_q    <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: directed cases followed by random traffic.
module tb_serial_adder_ctrl;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  typedef struct {
    logic [W:0]  res;
    int unsigned done_cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned free_edge = 0;
  int unsigned acc_edge = 0;
  bit          inflight = 1'b0;
  int          vectors = 0;
  int          miscompares = 0;
  logic [W:0]  hold = '0;
  bit          exp_done, exp_busy;

  task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  // Reference: a request is taken when no operation is pending or the previous
  // one has reached its done cycle; result appears WIDTH edges later.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sb.delete();
      free_edge = 0;
      inflight  = 1'b0;
    end else begin
      cyc++;
      if (start && cyc >= free_edge) begin
        sb.push_back('{res: {1'b0, a} + {1'b0, b} + (W+1)'(cin), done_cyc: cyc + W});
        acc_edge  = cyc;
        inflight  = 1'b1;
        free_edge = cyc + W + 1;
      end
    end
  end

  // Monitor: compare done/busy every cycle, pop the scoreboard on done, and
  // check that sum/cout hold the most recent result.
  always @(negedge clk) begin
    if (rst) begin
      hold = '0;
    end else begin
      exp_done = (sb.size() > 0) && (sb[0].done_cyc == cyc);
      exp_busy = inflight && (cyc >= acc_edge) && (cyc < acc_edge + W);
      check("done", (W+1)'(done), (W+1)'(exp_done));
      check("busy", (W+1)'(busy), (W+1)'(exp_busy));
      if (exp_done) hold = sb.pop_front().res;
      check("result", {cout, sum}, hold);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic);
    a = ia;
    b = ib;
    cin = ic;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    #2 rst = 1'b1;
    #1;
    check("rst_busy", (W+1)'(busy), '0);
    check("rst_done", (W+1)'(done), '0);
    check("rst_result", {cout, sum}, '0);
    step(2);
    rst = 1'b0;
    step();

    issue(8'h35, 8'h4A, 1'b0);
    step(W + 1);
    issue(8'hFF, 8'h01, 1'b0);
    step(W + 1);
    issue(8'hFF, 8'hFF, 1'b1);
    step(W + 1);

    // Start pulse during RUN cycle 3 must be ignored.
    issue(8'h10, 8'h20, 1'b0);
    step(2);
    issue(8'hAA, 8'h55, 1'b1);
    step(W + 1);

    // Asynchronous reset mid-operation, checked before any clock edge.
    issue(8'h55, 8'h22, 1'b0);
    step(3);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", (W+1)'(busy), '0);
    check("midrst_done", (W+1)'(done), '0);
    check("midrst_result", {cout, sum}, '0);
    step();
    rst = 1'b0;
    step();
    issue(8'h01, 8'h01, 1'b1);
    step(W + 1);

    // Back-to-back: start held through the DONE cycle.
    a = 8'h12;
    b = 8'h34;
    cin = 1'b0;
    start = 1'b1;
    step();
    a = 8'h80;
    b = 8'h80;
    step(W + 1);
    start = 1'b0;
    step(W + 2);

    for (int i = 0; i < 40; i++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom));
      repeat ($urandom_range(W - 1, W + 3)) begin
        if ($urandom_range(0, 5) == 0) begin
          a = W'($urandom);
          b = W'($urandom);
          cin = 1'($urandom);
          start = 1'b1;
        end else begin
          start = 1'b0;
        end
        step();
      end
      start = 1'b0;
    end

    step(W + 3);
    check("drain", (W+1)'(sb.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
